skin_bbox_detect: RTL and testbench

Per-pixel skin classifier and per-frame skin-region statistics stage. It sits directly downstream of the RGB→YCbCr converter and consumes that stage's Y/Cb/Cr and delayed `de`/`hsync`/`vsync`. For every active pixel it emits a 1-bit skin mask with re-aligned sync signals. For every completed frame it reports the skin-pixel count and the bounding box of skin pixels to the frame-level control logic.

---
 rtl/skin_pkg.sv | 31 +++
 rtl/skin_classify.sv | 35 +++
 rtl/skin_bbox_detect.sv | 180 ++++++++++++++++++
 tb/tb_skin_bbox_detect.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/skin_pkg.sv
// Shared definitions for the skin classifier / bounding-box stage.
// Holds default thresholds and widths, the frame FSM state type and the bbox
// record type used to describe a frame's skin statistics.
package skin_pkg;

  localparam int unsigned DEF_H_W        = 11;
  localparam int unsigned DEF_V_W        = 11;
  localparam int unsigned DEF_CNT_W      = 22;
  localparam int unsigned DEF_CB_MIN     = 77;
  localparam int unsigned DEF_CB_MAX     = 127;
  localparam int unsigned DEF_CR_MIN     = 133;
  localparam int unsigned DEF_CR_MAX     = 173;
  localparam int unsigned DEF_Y_MIN      = 40;
  localparam int unsigned DEF_MIN_PIXELS = 16;

  // SYNC: waiting for the first frame boundary; RUN: accumulating frames.
  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Per-frame skin statistics at the default widths.
  typedef struct packed {
    logic [DEF_H_W-1:0]   x_min;
    logic [DEF_H_W-1:0]   x_max;
    logic [DEF_V_W-1:0]   y_min;
    logic [DEF_V_W-1:0]   y_max;
    logic [DEF_CNT_W-1:0] count;
  } bbox_t;

endpackage

// File: rtl/skin_classify.sv
// Combinational skin test: inclusive Cb/Cr window, qualified by de.
// Optional luma gate via macro SKIN_LUMA_GATE_EN (requires y >= Y_MIN).
// Ports: de, y, cb, cr in; skin_c out (combinational).
module skin_classify
  import skin_pkg::*;
#(
  parameter int unsigned CB_MIN = DEF_CB_MIN,
  parameter int unsigned CB_MAX = DEF_CB_MAX,
  parameter int unsigned CR_MIN = DEF_CR_MIN,
  parameter int unsigned CR_MAX = DEF_CR_MAX,
  parameter int unsigned Y_MIN  = DEF_Y_MIN
) (
  input  logic       de,
  input  logic [7:0] y,
  input  logic [7:0] cb,
  input  logic [7:0] cr,
  output logic       skin_c
);

  logic in_cb;
  logic in_cr;

  assign in_cb = (cb >= 8'(CB_MIN)) && (cb <= 8'(CB_MAX));
  assign in_cr = (cr >= 8'(CR_MIN)) && (cr <= 8'(CR_MAX));

`ifdef SKIN_LUMA_GATE_EN
  assign skin_c = de & in_cb & in_cr & (y >= 8'(Y_MIN));
`else
  // Luma is ignored in this build.
  logic unused_luma;
  assign unused_luma = ^{y, 8'(Y_MIN)};
  assign skin_c = de & in_cb & in_cr;
`endif

endmodule

// File: rtl/skin_bbox_detect.sv
// Per-pixel skin mask plus per-frame skin count and bounding box.
// Optional luma gate: define SKIN_LUMA_GATE_EN.
// Ports: clk, rst_n (sync, active-low), ce (clock enable);
//   de_in/hsync_in/vsync_in, y_in/cb_in/cr_in: pixel stream in;
//   mask_out, de_out/hsync_out/vsync_out: 1-cycle delayed mask and syncs;
//   frame_valid: statistics update pulse; bbox_valid, x_min/x_max,
//   y_min/y_max, skin_count: statistics of the last completed frame.
module skin_bbox_detect
  import skin_pkg::*;
#(
  parameter int unsigned H_W        = DEF_H_W,
  parameter int unsigned V_W        = DEF_V_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned CB_MIN     = DEF_CB_MIN,
  parameter int unsigned CB_MAX     = DEF_CB_MAX,
  parameter int unsigned CR_MIN     = DEF_CR_MIN,
  parameter int unsigned CR_MAX     = DEF_CR_MAX,
  parameter int unsigned Y_MIN      = DEF_Y_MIN,
  parameter int unsigned MIN_PIXELS = DEF_MIN_PIXELS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             de_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [7:0]       y_in,
  input  logic [7:0]       cb_in,
  input  logic [7:0]       cr_in,
  output logic             mask_out,
  output logic             de_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             frame_valid,
  output logic             bbox_valid,
  output logic [H_W-1:0]   x_min,
  output logic [H_W-1:0]   x_max,
  output logic [V_W-1:0]   y_min,
  output logic [V_W-1:0]   y_max,
  output logic [CNT_W-1:0] skin_count
);

  logic skin_c;

  skin_classify #(
    .CB_MIN(CB_MIN),
    .CB_MAX(CB_MAX),
    .CR_MIN(CR_MIN),
    .CR_MAX(CR_MAX),
    .Y_MIN (Y_MIN)
  ) u_classify (
    .de    (de_in),
    .y     (y_in),
    .cb    (cb_in),
    .cr    (cr_in),
    .skin_c(skin_c)
  );

  logic           de_prev;
  logic           vs_prev;
  logic           de_fall;
  logic           vs_rise;
  logic [H_W-1:0] x;
  logic [V_W-1:0] y;
  state_t         state;

  logic [CNT_W-1:0] acc_cnt;
  logic [H_W-1:0]   acc_xmin;
  logic [H_W-1:0]   acc_xmax;
  logic [V_W-1:0]   acc_ymin;
  logic [V_W-1:0]   acc_ymax;

  logic [CNT_W-1:0] cnt_n;
  logic [H_W-1:0]   xmin_n;
  logic [H_W-1:0]   xmax_n;
  logic [V_W-1:0]   ymin_n;
  logic [V_W-1:0]   ymax_n;

  assign de_fall = de_prev & ~de_in;
  assign vs_rise = vsync_in & ~vs_prev;

  // Accumulators including the current pixel, so a skin pixel coinciding
  // with the vsync edge lands in the frame being closed.
  always_comb begin
    cnt_n  = acc_cnt;
    xmin_n = acc_xmin;
    xmax_n = acc_xmax;
    ymin_n = acc_ymin;
    ymax_n = acc_ymax;
    if (skin_c) begin
      if (acc_cnt != '1) cnt_n = acc_cnt + CNT_W'(1);
      if (x < acc_xmin)  xmin_n = x;
      if (x > acc_xmax)  xmax_n = x;
      if (y < acc_ymin)  ymin_n = y;
      if (y > acc_ymax)  ymax_n = y;
    end
  end

  // Output pipeline, edge-detect history and pixel coordinates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_out  <= 1'b0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      de_prev   <= 1'b0;
      vs_prev   <= 1'b0;
      x         <= '0;
      y         <= '0;
    end else if (ce) begin
      mask_out  <= skin_c;
      de_out    <= de_in;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      de_prev   <= de_in;
      vs_prev   <= vsync_in;
      if (de_in) begin
        if (x != '1) x <= x + H_W'(1);
      end else if (de_fall) begin
        x <= '0;
      end
      if (vs_rise) begin
        y <= '0;
      end else if (de_fall && (y != '1)) begin
        y <= y + V_W'(1);
      end
    end
  end

  // Frame FSM: accumulation and statistics hand-off at each vsync edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SYNC;
      frame_valid <= 1'b0;
      bbox_valid  <= 1'b0;
      x_min       <= '0;
      x_max       <= '0;
      y_min       <= '0;
      y_max       <= '0;
      skin_count  <= '0;
      acc_cnt     <= '0;
      acc_xmin    <= '1;
      acc_xmax    <= '0;
      acc_ymin    <= '1;
      acc_ymax    <= '0;
    end else if (ce) begin
      frame_valid <= 1'b0;
      case (state)
        SYNC: begin
          // Partial first frame is discarded; accumulators stay at init.
          if (vs_rise) state <= RUN;
        end
        RUN: begin
          if (vs_rise) begin
            frame_valid <= 1'b1;
            bbox_valid  <= (cnt_n >= CNT_W'(MIN_PIXELS));
            skin_count  <= cnt_n;
            x_min       <= xmin_n;
            x_max       <= xmax_n;
            y_min       <= ymin_n;
            y_max       <= ymax_n;
            acc_cnt     <= '0;
            acc_xmin    <= '1;
            acc_xmax    <= '0;
            acc_ymin    <= '1;
            acc_ymax    <= '0;
          end else begin
            acc_cnt  <= cnt_n;
            acc_xmin <= xmin_n;
            acc_xmax <= xmax_n;
            acc_ymin <= ymin_n;
            acc_ymax <= ymax_n;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_skin_bbox_detect.sv
// Self-checking bench for skin_bbox_detect: directed frames plus random
// frames, compared against a frame-level model of skin statistics.
module tb_skin_bbox_detect;
  import skin_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, ce, de, hs, vs;
  logic [7:0]  yv, cb, cr;
  logic        mask_out, de_out, hsync_out, vsync_out, frame_valid, bbox_valid;
  logic [10:0] x_min, x_max, y_min, y_max;
  logic [21:0] skin_count;

  skin_bbox_detect dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .de_in(de), .hsync_in(hs), .vsync_in(vs),
    .y_in(yv), .cb_in(cb), .cr_in(cr),
    .mask_out(mask_out), .de_out(de_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .frame_valid(frame_valid), .bbox_valid(bbox_valid),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .skin_count(skin_count)
  );

  always #5 clk = ~clk;

`ifdef SKIN_LUMA_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] img_y [16][32];
  logic [7:0] img_cb[16][32];
  logic [7:0] img_cr[16][32];

  // Model state
  logic  in_run, pv, gate;
  int    m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
  bbox_t held;
  logic  held_bv;
  logic  last_mask, last_de, last_fv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic cls(input logic d, input logic [7:0] yy,
                               input logic [7:0] b, input logic [7:0] r);
    logic s;
    s = d && (b >= 8'd77) && (b <= 8'd127) && (r >= 8'd133) && (r <= 8'd173);
    s = s && (!GATE || (yy >= 8'd40));
    return s;
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_xmin = 2047; m_xmax = 0; m_ymin = 2047; m_ymax = 0;
  endtask

  // One ce=1 pixel cycle at frame coordinate (col,row); optional ce=0 gap first.
  task automatic step(input int col, input int row);
    logic exp_mask, rise, exp_fv;
    logic sd, sh, sv;
    logic [7:0] sy, sb, sr;
    if (gate) begin
      sd = de; sh = hs; sv = vs; sy = yv; sb = cb; sr = cr;
      ce = 1'b0; de = 1'($urandom); hs = 1'($urandom); vs = 1'b1;
      yv = 8'($urandom); cb = 8'($urandom); cr = 8'($urandom);
      @(posedge clk); #1;
      chk("gap_mask", 32'(mask_out), 32'(last_mask));
      chk("gap_de", 32'(de_out), 32'(last_de));
      chk("gap_fv", 32'(frame_valid), 32'(last_fv));
      chk("gap_cnt", 32'(skin_count), 32'(held.count));
      de = sd; hs = sh; vs = sv; yv = sy; cb = sb; cr = sr; ce = 1'b1;
    end
    exp_mask = cls(de, yv, cb, cr);
    rise = vs && !pv;
    if (in_run && exp_mask) begin
      m_cnt++;
      if (col < m_xmin) m_xmin = col;
      if (col > m_xmax) m_xmax = col;
      if (row < m_ymin) m_ymin = row;
      if (row > m_ymax) m_ymax = row;
    end
    @(posedge clk); #1;
    chk("mask", 32'(mask_out), 32'(exp_mask));
    chk("de_out", 32'(de_out), 32'(de));
    chk("hsync_out", 32'(hsync_out), 32'(hs));
    chk("vsync_out", 32'(vsync_out), 32'(vs));
    exp_fv = rise && in_run;
    chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
    if (exp_fv) begin
      held.count = 22'(m_cnt);
      held.x_min = 11'(m_xmin); held.x_max = 11'(m_xmax);
      held.y_min = 11'(m_ymin); held.y_max = 11'(m_ymax);
      held_bv    = (m_cnt >= 16);
    end
    chk("skin_count", 32'(skin_count), 32'(held.count));
    chk("x_min", 32'(x_min), 32'(held.x_min));
    chk("x_max", 32'(x_max), 32'(held.x_max));
    chk("y_min", 32'(y_min), 32'(held.y_min));
    chk("y_max", 32'(y_max), 32'(held.y_max));
    chk("bbox_valid", 32'(bbox_valid), 32'(held_bv));
    if (rise) begin in_run = 1'b1; model_clear(); end
    pv = vs; last_mask = exp_mask; last_de = de; last_fv = exp_fv;
  endtask

  task automatic vsync_pulse();
    de = 0; hs = 0; yv = 0; cb = 0; cr = 0;
    vs = 1; step(0, 0); step(0, 0);
    vs = 0; step(0, 0); step(0, 0);
  endtask

  task automatic frame(input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        de = 1; hs = 0; vs = 0;
        yv = img_y[r][c]; cb = img_cb[r][c]; cr = img_cr[r][c];
        step(c, r);
      end
      de = 0; yv = 0; cb = 0; cr = 0;
      step(0, 0); hs = 1; step(0, 0); hs = 0; step(0, 0);
    end
  endtask

  task automatic fill_bg();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++) begin
        img_y[r][c] = 8'd128; img_cb[r][c] = 8'd0; img_cr[r][c] = 8'd0;
      end
  endtask

  task automatic set_skin(input int c, input int r);
    img_cb[r][c] = 8'd100; img_cr[r][c] = 8'd150;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++) begin
        img_y[r][c] = 8'($urandom);
        if ($urandom_range(2) == 0) begin
          img_cb[r][c] = 8'($urandom_range(135, 70));
          img_cr[r][c] = 8'($urandom_range(180, 125));
        end else begin
          img_cb[r][c] = 8'($urandom); img_cr[r][c] = 8'($urandom);
        end
      end
  endtask

  initial begin
    gate = 0; in_run = 0; pv = 0; held = '0; held_bv = 0;
    last_mask = 0; last_de = 0; last_fv = 0;
    model_clear();

    // Reset with random inputs
    rst_n = 0; ce = 1;
    for (int i = 0; i < 3; i++) begin
      de = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
      yv = 8'($urandom); cb = 8'($urandom); cr = 8'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_mask", 32'(mask_out), 0);
    chk("rst_de", 32'(de_out), 0);
    chk("rst_hs", 32'(hsync_out), 0);
    chk("rst_vs", 32'(vsync_out), 0);
    chk("rst_fv", 32'(frame_valid), 0);
    chk("rst_bv", 32'(bbox_valid), 0);
    chk("rst_xmin", 32'(x_min), 0);
    chk("rst_xmax", 32'(x_max), 0);
    chk("rst_ymin", 32'(y_min), 0);
    chk("rst_ymax", 32'(y_max), 0);
    chk("rst_cnt", 32'(skin_count), 0);
    de = 0; hs = 0; vs = 0; yv = 0; cb = 0; cr = 0;
    rst_n = 1;
    step(0, 0);

    // First vsync: no report. Second vsync closes an empty frame.
    vsync_pulse();
    vsync_pulse();
    chk("empty_cnt", 32'(skin_count), 0);
    chk("empty_bv", 32'(bbox_valid), 0);
    chk("empty_xmin", 32'(x_min), 2047);
    chk("empty_xmax", 32'(x_max), 0);

    // Window edges: 8x4 with column pattern
    fill_bg();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        case (c % 4)
          0: begin img_cb[r][c] = 8'd77;  img_cr[r][c] = 8'd133; end
          1: begin img_cb[r][c] = 8'd127; img_cr[r][c] = 8'd173; end
          2: begin img_cb[r][c] = 8'd76;  img_cr[r][c] = 8'd150; end
          default: begin img_cb[r][c] = 8'd100; img_cr[r][c] = 8'd174; end
        endcase
      end
    frame(8, 4);
    vsync_pulse();

    // Bounding box 16x8
    fill_bg();
    set_skin(3, 2); set_skin(10, 2); set_skin(5, 6); set_skin(7, 5);
    for (int r = 3; r <= 4; r++)
      for (int c = 4; c <= 9; c++) set_skin(c, r);
    frame(16, 8);
    vsync_pulse();
    chk("bbox_cnt", 32'(skin_count), 16);
    chk("bbox_xmin", 32'(x_min), 3);
    chk("bbox_xmax", 32'(x_max), 10);
    chk("bbox_ymin", 32'(y_min), 2);
    chk("bbox_ymax", 32'(y_max), 6);
    chk("bbox_bv", 32'(bbox_valid), 1);

    // Luma boundary 39/40
    fill_bg();
    for (int c = 0; c < 4; c++) begin
      set_skin(c, 0); img_y[0][c] = (c % 2 == 0) ? 8'd39 : 8'd40;
    end
    frame(4, 1);
    vsync_pulse();

    // Random frames, some with ce toggling and stray vsync during ce=0
    for (int f = 0; f < 6; f++) begin
      fill_rand();
      gate = (f % 2 == 1);
      frame(4 + int'($urandom_range(28)), 2 + int'($urandom_range(14)));
      vsync_pulse();
      gate = 0;
    end

    // Skin pixel coincident with the vsync rise belongs to the closing frame
    fill_bg();
    frame(4, 2);
    vs = 1; de = 1; yv = 8'd128; cb = 8'd100; cr = 8'd150;
    step(0, 2);
    de = 0; yv = 0; cb = 0; cr = 0;
    step(0, 0);
    vs = 0; step(0, 0); step(0, 0);
    chk("coin_cnt", 32'(skin_count), 1);
    chk("coin_xmin", 32'(x_min), 0);
    chk("coin_ymax", 32'(y_max), 2);
    chk("coin_bv", 32'(bbox_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
